// File: rtl/div_unit_pkg.sv
// Shared ALU definitions used by the divider.
//   DIV_WIDTH      default operand width
//   state_t        divider sequencing states
//   REM_HI/QUO_LO  WIDTH-sized slot indices of the 2*WIDTH Result word
//                  (Result[REM_HI*WIDTH +: WIDTH] is the remainder)
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP,
        DONE
    } state_t;

    localparam int unsigned REM_HI = 1;
    localparam int unsigned QUO_LO = 0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration, purely combinational.
//   rem       current partial remainder (always < divisor)
//   dvd_msb   dividend bit shifted in this iteration
//   divisor   |B|
//   rem_next  partial remainder after the trial subtraction
//   q_bit     quotient bit produced by this iteration
module div_step
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem, dvd_msb};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the trial succeeds the difference is < divisor, so WIDTH bits suffice.
        diff     = shifted[WIDTH-1:0] - divisor;
        rem_next = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider, one restoring step per clock.
//   clock        rising-edge clock
//   clear        synchronous active-high reset
//   start        request, accepted in IDLE and DONE only
//   A, B         signed dividend / divisor, sampled on accept
//   busy         high while iterating (RUN) and fixing signs (FIXUP)
//   done         one-cycle pulse when Result becomes valid
//   div_by_zero  raised with done when B was zero, held with Result
//   Result       {remainder, quotient}; quotient truncates toward zero,
//                remainder carries the dividend's sign
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
)
(
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] Result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;          // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0] divisor_mag;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    // Most-negative magnitude is exactly representable as unsigned WIDTH bits.
    always_comb begin
        a_mag = A[WIDTH-1] ? -A : A;
        b_mag = B[WIDTH-1] ? -B : B;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (divisor_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            dvd         <= '0;
            divisor_mag <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Result      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        divisor_mag <= b_mag;
                        dvd         <= a_mag;
                        rem         <= '0;
                        count       <= '0;
                        neg_r       <= A[WIDTH-1];
                        neg_q       <= A[WIDTH-1] ^ B[WIDTH-1];
                        div_by_zero <= 1'b0;
                        if (B == '0) begin
                            Result      <= {A, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    Result[REM_HI*WIDTH +: WIDTH] <= neg_r ? -rem : rem;
                    Result[QUO_LO*WIDTH +: WIDTH] <= neg_q ? -dvd : dvd;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
